// File: rtl/next_line_prefetcher_if.sv
// Handshake bundle between the next-line prefetcher, the cache and the memory arbiter.
// master: the prefetcher view (drives the memory read request and the buffered line).
// slave:  the environment view (drives the trigger, the memory response and the ack).
interface next_line_prefetcher_if;
    // demand-miss trigger from the cache
    logic         trigger_valid;
    logic [31:0]  trigger_address;
    // memory arbiter request/response
    logic         pf_mem_read;
    logic [31:0]  pf_mem_address;
    logic         pf_mem_resp;
    logic [255:0] pf_mem_rdata;
    // buffered line offered back to the cache
    logic         prefetch_ready;
    logic [255:0] prefetch_rdata;
    logic [31:0]  pf_cline_address;
    logic         prefetch_ack;

    modport master (
        input  trigger_valid, trigger_address, pf_mem_resp, pf_mem_rdata, prefetch_ack,
        output pf_mem_read, pf_mem_address, prefetch_ready, prefetch_rdata, pf_cline_address
    );

    modport slave (
        output trigger_valid, trigger_address, pf_mem_resp, pf_mem_rdata, prefetch_ack,
        input  pf_mem_read, pf_mem_address, prefetch_ready, prefetch_rdata, pf_cline_address
    );
endinterface

// File: rtl/next_line_prefetcher.sv
// Purpose: on a demand miss, fetch the next cacheline and hold it in a one-line buffer for the cache.
// Latency: accepted trigger at N -> pf_mem_read at N+1; pf_mem_resp at M -> prefetch_ready at M+1.
// Backpressure: request held until pf_mem_resp, line held until prefetch_ack; one pending trigger, newest wins.
//
// Ports: clk (rising edge), rst (async active-low), pf (next_line_prefetcher_if.master):
//   trigger_valid/trigger_address in; pf_mem_read/pf_mem_address out, pf_mem_resp/pf_mem_rdata in;
//   prefetch_ready/prefetch_rdata/pf_cline_address out, prefetch_ack in.
// Build option: define PF_PAGE_CROSS_EN to allow next-line targets that cross a 2**s_page boundary.
module next_line_prefetcher #(
    parameter int s_offset = 5,
    parameter int s_page   = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    next_line_prefetcher_if.master   pf
);

    localparam int LW = 32 - s_offset;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [31:0]    line_addr, line_addr_nxt;
    logic [255:0]   line_dat, line_dat_nxt;
    logic [31:0]    pend_addr, pend_addr_nxt;
    logic           pend_vld, pend_vld_nxt;

    logic [LW-1:0]  tgt_idx;
    logic [31:0]    tgt_addr;
    logic           page_drop;
    logic           dup_drop;
    logic           trig_acc;

    // Line index + 1 with the carry discarded; a wrap to line 0 is dropped below.
    assign tgt_idx  = pf.trigger_address[31:s_offset] + LW'(1);
    assign tgt_addr = {tgt_idx, {s_offset{1'b0}}};

`ifdef PF_PAGE_CROSS_EN
    assign page_drop = 1'b0;
`else
    // Last line of a page: the next line lives in another page, which may not be mapped.
    assign page_drop = &pf.trigger_address[s_page-1:s_offset];
`endif

    // line_addr is only meaningful while a transfer is active, hence the state qualifier.
    assign dup_drop = ((state != IDLE) && (tgt_addr == line_addr)) ||
                      (pend_vld && (tgt_addr == pend_addr));

    assign trig_acc = pf.trigger_valid && (tgt_addr != 32'd0) && !page_drop && !dup_drop;

    always_comb begin
        state_nxt     = state;
        line_addr_nxt = line_addr;
        line_dat_nxt  = line_dat;
        pend_addr_nxt = pend_addr;
        pend_vld_nxt  = pend_vld;

        case (state)
            IDLE: begin
                if (trig_acc) begin
                    state_nxt     = REQ;
                    line_addr_nxt = tgt_addr;
                end
            end

            REQ: begin
                if (pf.pf_mem_resp) begin
                    state_nxt    = HOLD;
                    line_dat_nxt = pf.pf_mem_rdata;
                end
                if (trig_acc) begin
                    pend_addr_nxt = tgt_addr;
                    pend_vld_nxt  = 1'b1;
                end
            end

            HOLD: begin
                if (pf.prefetch_ack) begin
                    // A trigger arriving with the ack is fresher than the pending entry.
                    pend_vld_nxt = 1'b0;
                    if (trig_acc) begin
                        state_nxt     = REQ;
                        line_addr_nxt = tgt_addr;
                    end else if (pend_vld) begin
                        state_nxt     = REQ;
                        line_addr_nxt = pend_addr;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (trig_acc) begin
                    pend_addr_nxt = tgt_addr;
                    pend_vld_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt    = IDLE;
                pend_vld_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            line_addr <= 32'd0;
            line_dat  <= 256'd0;
            pend_addr <= 32'd0;
            pend_vld  <= 1'b0;
        end else begin
            state     <= state_nxt;
            line_addr <= line_addr_nxt;
            line_dat  <= line_dat_nxt;
            pend_addr <= pend_addr_nxt;
            pend_vld  <= pend_vld_nxt;
        end
    end

    // Outputs decode straight from registered state so reset clears them without a clock.
    assign pf.pf_mem_read      = (state == REQ);
    assign pf.pf_mem_address   = line_addr;
    assign pf.prefetch_ready   = (state == HOLD);
    assign pf.prefetch_rdata   = line_dat;
    assign pf.pf_cline_address = line_addr;

endmodule
